// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/execute front end.
package cpu_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OFFSET_W = 16;
  localparam int unsigned JIDX_W   = 26;

  // Bubble encoding: sll $0,$0,0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'b00,
    REDIR_BR   = 2'b01,
    REDIR_J    = 2'b10,
    REDIR_JR   = 2'b11
  } redir_kind_e;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } seq_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory, redirect and FETCH->EX signals of the fetch sequencer.
interface fetch_sequencer_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 12
);

  logic [PC_WIDTH-1:0] imem_addr;
  logic [INSTR_W-1:0]  imem_rdata;
  logic                stall_i;
  logic                halt_i;
  redir_kind_e         redir_kind_i;
  logic [OFFSET_W-1:0] br_offset_i;
  logic [JIDX_W-1:0]   j_index_i;
  logic [31:0]         jr_target_i;
  logic [INSTR_W-1:0]  instr_ex;
  logic [PC_WIDTH-1:0] pc_ex;
  logic                valid_ex;
  logic                halted;
  logic [31:0]         retired_cnt;

  // Sequencer side
  modport master (
    output imem_addr, instr_ex, pc_ex, valid_ex, halted, retired_cnt,
    input  imem_rdata, stall_i, halt_i, redir_kind_i, br_offset_i,
           j_index_i, jr_target_i
  );

  // Memory / execute-stage side
  modport slave (
    input  imem_addr, instr_ex, pc_ex, valid_ex, halted, retired_cnt,
    output imem_rdata, stall_i, halt_i, redir_kind_i, br_offset_i,
           j_index_i, jr_target_i
  );

endinterface

// File: rtl/pc_target_calc.sv
// Redirect target for the instruction currently in EX; all arithmetic wraps mod 2**PC_WIDTH.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 12
) (
  input  logic [PC_WIDTH-1:0] pc_ex,
  input  redir_kind_e         kind,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic [JIDX_W-1:0]   j_index,
  input  logic [31:0]         jr_target,
  output logic [PC_WIDTH-1:0] target_c
);

  logic [31:0] off_sext;

  assign off_sext = {{(32 - OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};

  // Select target by redirect kind; JR drops the byte-offset bits
  always_comb begin
    target_c = pc_ex;
    case (kind)
      REDIR_BR: target_c = pc_ex + PC_WIDTH'(1) + PC_WIDTH'(off_sext);
      REDIR_J:  target_c = PC_WIDTH'(j_index);
      REDIR_JR: target_c = PC_WIDTH'(jr_target >> 2);
      default:  target_c = pc_ex;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, FETCH->EX pipeline register and retire counter of the two-stage core.
module fetch_sequencer #(
  parameter int unsigned PC_WIDTH  = 12,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  import cpu_pkg::*;

  seq_state_e          state;
  logic [PC_WIDTH-1:0] pc_fetch;
  logic [INSTR_W-1:0]  instr_ex;
  logic [PC_WIDTH-1:0] pc_ex;
  logic                valid_ex;
  logic                halted;
  logic [31:0]         retired_cnt;
  logic [PC_WIDTH-1:0] target_c;

  // Redirect target for the instruction in EX
  pc_target_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_target (
    .pc_ex     (pc_ex),
    .kind      (bus.redir_kind_i),
    .br_offset (bus.br_offset_i),
    .j_index   (bus.j_index_i),
    .jr_target (bus.jr_target_i),
    .target_c  (target_c)
  );

  // Sequencer state, PC, EX register and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc_fetch    <= '0;
      instr_ex    <= NOP_INSTR;
      pc_ex       <= '0;
      valid_ex    <= 1'b0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          instr_ex <= bus.imem_rdata;
          pc_ex    <= pc_fetch;
          valid_ex <= 1'b1;
          pc_fetch <= pc_fetch + PC_WIDTH'(1);
          state    <= RUN;
        end
        RUN: begin
          if (!bus.stall_i) begin
            if (valid_ex) begin
              retired_cnt <= retired_cnt + 32'd1;
            end
            if (valid_ex && bus.halt_i) begin
              // Halting instruction retires; pipeline drains to a bubble for good
              instr_ex <= NOP_INSTR;
              valid_ex <= 1'b0;
              halted   <= 1'b1;
              state    <= HALT;
            end else if (valid_ex && (bus.redir_kind_i != REDIR_NONE)) begin
              // Squash the sequential fetch; no delay slot
              pc_fetch <= target_c;
              instr_ex <= NOP_INSTR;
              valid_ex <= 1'b0;
            end else begin
              instr_ex <= bus.imem_rdata;
              pc_ex    <= pc_fetch;
              valid_ex <= 1'b1;
              pc_fetch <= pc_fetch + PC_WIDTH'(1);
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_fetch;
  assign bus.instr_ex    = instr_ex;
  assign bus.pc_ex       = pc_ex;
  assign bus.valid_ex    = valid_ex;
  assign bus.halted      = halted;
  assign bus.retired_cnt = retired_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an expected-result queue.
module tb_fetch_sequencer;

  import cpu_pkg::*;

  localparam int unsigned PC_WIDTH = 12;
  localparam int unsigned DEPTH    = 1 << PC_WIDTH;

  typedef struct packed {
    logic [31:0] instr;
    logic [11:0] pc;
    logic        chk_pc;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
    logic [11:0] fpc;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t exp_q[$];
  logic [31:0] imem [DEPTH];

  fetch_sequencer_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  fetch_sequencer #(.PC_WIDTH(PC_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata = imem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [11:0] pc,
                              input logic chk_pc, input logic valid, input logic halted,
                              input logic [31:0] cnt, input logic [11:0] fpc);
    exp_t e;
    e.instr  = instr;
    e.pc     = pc;
    e.chk_pc = chk_pc;
    e.valid  = valid;
    e.halted = halted;
    e.cnt    = cnt;
    e.fpc    = fpc;
    return e;
  endfunction

  // Queue the expectation, advance one edge, then compare what EX holds
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, ".instr"}, bus.instr_ex, got.instr);
    if (got.chk_pc) check({tag, ".pc_ex"}, 32'(bus.pc_ex), 32'(got.pc));
    check({tag, ".valid"}, 32'(bus.valid_ex), 32'(got.valid));
    check({tag, ".halted"}, 32'(bus.halted), 32'(got.halted));
    check({tag, ".retired"}, bus.retired_cnt, got.cnt);
    check({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(got.fpc));
  endtask

  task automatic drive(input logic stall, input logic halt, input redir_kind_e kind);
    bus.stall_i      = stall;
    bus.halt_i       = halt;
    bus.redir_kind_i = kind;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < int'(DEPTH); i++) imem[i] = 32'(i + 1);
    rst             = 1'b0;
    bus.stall_i     = 1'b0;
    bus.halt_i      = 1'b0;
    bus.redir_kind_i = REDIR_NONE;
    bus.br_offset_i = '0;
    bus.j_index_i   = '0;
    bus.jr_target_i = '0;

    // Reset values
    #12;
    check("rst.instr", bus.instr_ex, NOP_INSTR);
    check("rst.pc_ex", 32'(bus.pc_ex), 32'd0);
    check("rst.valid", 32'(bus.valid_ex), 32'd0);
    check("rst.halted", 32'(bus.halted), 32'd0);
    check("rst.retired", bus.retired_cnt, 32'd0);
    check("rst.imem_addr", 32'(bus.imem_addr), 32'd0);
    rst = 1'b1;

    // Boot and sequential fetch
    step("seq1", mk(32'd1, 12'd0, 1'b1, 1'b1, 1'b0, 32'd0, 12'd1));
    step("seq2", mk(32'd2, 12'd1, 1'b1, 1'b1, 1'b0, 32'd1, 12'd2));
    step("seq3", mk(32'd3, 12'd2, 1'b1, 1'b1, 1'b0, 32'd2, 12'd3));
    step("seq4", mk(32'd4, 12'd3, 1'b1, 1'b1, 1'b0, 32'd3, 12'd4));
    step("seq5", mk(32'd5, 12'd4, 1'b1, 1'b1, 1'b0, 32'd4, 12'd5));
    step("seq6", mk(32'd6, 12'd5, 1'b1, 1'b1, 1'b0, 32'd5, 12'd6));

    // Backward branch from pc_ex=5, offset -3 -> 3
    bus.br_offset_i = 16'hFFFD;
    drive(1'b0, 1'b0, REDIR_BR);
    step("br.bubble", mk(NOP_INSTR, 12'd0, 1'b0, 1'b0, 1'b0, 32'd6, 12'd3));
    // Redirect held high across the bubble must be ignored
    step("br.target", mk(32'd4, 12'd3, 1'b1, 1'b1, 1'b0, 32'd6, 12'd4));
    drive(1'b0, 1'b0, REDIR_NONE);
    step("br.next", mk(32'd5, 12'd4, 1'b1, 1'b1, 1'b0, 32'd7, 12'd5));

    // Stall 3 cycles with a pending branch (4+1+2 = 7)
    bus.br_offset_i = 16'h0002;
    drive(1'b1, 1'b0, REDIR_BR);
    step("stall1", mk(32'd5, 12'd4, 1'b1, 1'b1, 1'b0, 32'd7, 12'd5));
    step("stall2", mk(32'd5, 12'd4, 1'b1, 1'b1, 1'b0, 32'd7, 12'd5));
    step("stall3", mk(32'd5, 12'd4, 1'b1, 1'b1, 1'b0, 32'd7, 12'd5));
    drive(1'b0, 1'b0, REDIR_BR);
    step("stall.redir", mk(NOP_INSTR, 12'd0, 1'b0, 1'b0, 1'b0, 32'd8, 12'd7));
    drive(1'b0, 1'b0, REDIR_NONE);
    step("stall.target", mk(32'd8, 12'd7, 1'b1, 1'b1, 1'b0, 32'd8, 12'd8));

    // Jump register: byte address 0x4008 -> word 0x002 after wrap
    bus.jr_target_i = 32'h0000_4008;
    drive(1'b0, 1'b0, REDIR_JR);
    step("jr.bubble", mk(NOP_INSTR, 12'd0, 1'b0, 1'b0, 1'b0, 32'd9, 12'h002));
    drive(1'b0, 1'b0, REDIR_NONE);
    step("jr.target", mk(32'd3, 12'h002, 1'b1, 1'b1, 1'b0, 32'd9, 12'h003));

    // Jump to the top of memory, then sequential wrap to 0
    bus.j_index_i = 26'h3FF_FFFF;
    drive(1'b0, 1'b0, REDIR_J);
    step("j.bubble", mk(NOP_INSTR, 12'd0, 1'b0, 1'b0, 1'b0, 32'd10, 12'hFFF));
    drive(1'b0, 1'b0, REDIR_NONE);
    step("j.target", mk(32'h1000, 12'hFFF, 1'b1, 1'b1, 1'b0, 32'd10, 12'h000));
    step("wrap", mk(32'd1, 12'h000, 1'b1, 1'b1, 1'b0, 32'd11, 12'h001));

    // Halt held off by stall, then taken
    drive(1'b1, 1'b1, REDIR_NONE);
    step("halt.stalled", mk(32'd1, 12'h000, 1'b1, 1'b1, 1'b0, 32'd11, 12'h001));
    drive(1'b0, 1'b1, REDIR_NONE);
    step("halt.enter", mk(NOP_INSTR, 12'd0, 1'b0, 1'b0, 1'b1, 32'd12, 12'h001));
    drive(1'b0, 1'b0, REDIR_J);
    step("halt.frozen1", mk(NOP_INSTR, 12'd0, 1'b0, 1'b0, 1'b1, 32'd12, 12'h001));
    drive(1'b1, 1'b1, REDIR_BR);
    step("halt.frozen2", mk(NOP_INSTR, 12'd0, 1'b0, 1'b0, 1'b1, 32'd12, 12'h001));

    // Asynchronous reset in the middle of HALT
    drive(1'b0, 1'b0, REDIR_NONE);
    #2;
    rst = 1'b0;
    #1;
    check("arst.halted", 32'(bus.halted), 32'd0);
    check("arst.imem_addr", 32'(bus.imem_addr), 32'd0);
    check("arst.retired", bus.retired_cnt, 32'd0);
    check("arst.valid", 32'(bus.valid_ex), 32'd0);
    check("arst.instr", bus.instr_ex, NOP_INSTR);
    @(negedge clk);
    rst = 1'b1;
    step("reboot", mk(32'd1, 12'd0, 1'b1, 1'b1, 1'b0, 32'd0, 12'd1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
